// File: rtl/accumulate_round_saturate_if.sv
// Handshake bundle for accumulate_round_saturate: term input stream and rounded result stream.
// master = producer/consumer side, slave = the accumulator.
interface accumulate_round_saturate_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_data;
  logic [W-1:0]   in_bias;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_sat;

  // Both sides follow valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender keeps payload stable while valid waits for ready.
  modport master (
    output in_valid, in_data, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/accumulate_round_saturate.sv
// Sums K wide signed terms plus a bias, then rounds (ties toward +inf) and saturates
// the result back to a W-bit Q(I).(W-I) value presented on a valid/ready output.
module accumulate_round_saturate #(
  parameter int W = 16,
  parameter int I = 4,
  parameter int K = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  accumulate_round_saturate_if.slave bus,
  output logic [1:0]                 o_dbg_state
);

  localparam int FS    = W - I;
  localparam int CW    = (K > 1) ? $clog2(K) : 1;
  localparam int ACC_W = 2 * W + $clog2(K) + 2;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [CW-1:0]          CNT_LAST = CW'(K - 1);
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FS - 1);

  logic [1:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic [W-1:0]            r_out_data;
  logic                    r_out_sat;

  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_bias;
  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_r;
  logic                    w_fits;

  // The bias sits at W-I fractional bits; shifting aligns it with the 2(W-I) terms.
  assign w_term = ACC_W'($signed(bus.in_data));
  assign w_bias = ACC_W'($signed(bus.in_bias)) <<< FS;
  assign w_rnd  = r_acc + HALF;
  assign w_r    = w_rnd >>> FS;
  // The rounded value fits in W bits iff every bit above W-1 copies its sign bit.
  assign w_fits = (w_r[ACC_W-1:W-1] == {(ACC_W-W+1){w_r[W-1]}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACCUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            if (r_cnt == '0) r_acc <= w_bias + w_term;
            else             r_acc <= r_acc + w_term;
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_ROUND;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_ROUND: begin
          if (w_fits) begin
            r_out_data <= w_r[W-1:0];
            r_out_sat  <= 1'b0;
          end else begin
            r_out_data <= w_r[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            r_out_sat  <= 1'b1;
          end
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_state     <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_ACCUM);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_accumulate_round_saturate.sv
// Directed and randomized bench for accumulate_round_saturate (W=16, I=4, K=4)
// with an arithmetic reference model and an expected-result queue.
module tb_accumulate_round_saturate;

  localparam int W = 16;
  localparam int I = 4;
  localparam int K = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  accumulate_round_saturate_if #(.W(W)) bus ();

  accumulate_round_saturate #(.W(W), .I(I), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int          n_checks;
  int          n_fail;
  logic [16:0] exp_q[$];
  logic [31:0] tv [4];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bias   = '0;
    bus.out_ready = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact sum in Q.24, round half up to Q.12, clamp to 16 bits.
  function automatic logic [16:0] model(input logic [15:0] bias);
    longint s;
    longint r;
    s = longint'($signed(bias)) * 4096;
    for (int i = 0; i < K; i++) s += longint'($signed(tv[i]));
    r = (s + 2048) >>> 12;
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, 16'(r)};
  endfunction

  function automatic logic [31:0] rand_term();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) == 0) return v;
    return {{7{v[25]}}, v[24:0]};
  endfunction

  task automatic set_tv(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    tv[0] = a; tv[1] = b; tv[2] = c; tv[3] = d;
  endtask

  // driver: present n terms from tv, first one carrying the bias
  task automatic drive_terms(input logic [15:0] bias, input int n, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int j = 0; j < idle; j++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_data  = $urandom;
          bus.in_bias  = 16'($urandom);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = tv[i];
      bus.in_bias  = (i == 0) ? bias : 16'($urandom);
      check("in_ready_accum", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // receiver: out_valid must appear one cycle after the last term, then be held for `hold` cycles
  task automatic collect(input int hold);
    logic [16:0] exp;
    exp = exp_q.pop_front();
    @(negedge clk);
    check("out_valid_latency", 32'(bus.out_valid), 32'd1);
    check("result", 32'({bus.out_sat, bus.out_data}), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_result", 32'({bus.out_sat, bus.out_data}), 32'(exp));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic run_group(input logic [15:0] bias, input bit use_exp, input logic [16:0] exp,
                           input bit bubbles, input int hold);
    exp_q.push_back(use_exp ? exp : model(bias));
    drive_terms(bias, K, bubbles);
    check("round_out_valid", 32'(bus.out_valid), 32'd0);
    check("round_in_ready", 32'(bus.in_ready), 32'd0);
    collect(hold);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_out_sat", 32'(bus.out_sat), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // basic sum and bias
    set_tv(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    run_group(16'h0000, 1'b1, {1'b0, 16'h4000}, 1'b0, 0);
    set_tv(32'h0, 32'h0, 32'h0, 32'h0);
    run_group(16'h1000, 1'b1, {1'b0, 16'h1000}, 1'b0, 0);
    set_tv(32'h0100_0000, 32'h0, 32'h0, 32'h0);
    run_group(16'hF000, 1'b1, {1'b0, 16'h0000}, 1'b0, 0);

    // rounding ties and near-ties
    set_tv(32'h0000_0800, 32'h0, 32'h0, 32'h0);
    run_group(16'h0000, 1'b1, {1'b0, 16'h0001}, 1'b0, 0);
    set_tv(32'h0000_07FF, 32'h0, 32'h0, 32'h0);
    run_group(16'h0000, 1'b1, {1'b0, 16'h0000}, 1'b0, 0);
    set_tv(32'hFFFF_F800, 32'h0, 32'h0, 32'h0);
    run_group(16'h0000, 1'b1, {1'b0, 16'h0000}, 1'b0, 0);
    set_tv(32'hFFFF_F7FF, 32'h0, 32'h0, 32'h0);
    run_group(16'h0000, 1'b1, {1'b0, 16'hFFFF}, 1'b0, 0);

    // saturation
    set_tv(32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000);
    run_group(16'h0000, 1'b1, {1'b1, 16'h7FFF}, 1'b0, 0);
    set_tv(32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000);
    run_group(16'h0000, 1'b1, {1'b1, 16'h8000}, 1'b0, 0);
    set_tv(32'h0, 32'h0, 32'h0, 32'h0);
    run_group(16'h7FFF, 1'b1, {1'b0, 16'h7FFF}, 1'b0, 0);

    // backpressure with input bubbles
    set_tv(32'h0123_4567, 32'hFF00_8000, 32'h0040_0000, 32'h0000_0FFF);
    run_group(16'h0A00, 1'b0, '0, 1'b1, 5);

    // reset mid-group drops the partial sum
    set_tv(32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0);
    drive_terms(16'h1000, 2, 1'b0);
    reset_pulse();
    set_tv(32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000);
    run_group(16'h0000, 1'b1, {1'b0, 16'h2000}, 1'b0, 0);

    // reset while a result waits in HOLD
    set_tv(32'h0100_0000, 32'h0, 32'h0, 32'h0);
    drive_terms(16'h0000, K, 1'b0);
    @(negedge clk);
    check("hold_before_rst", 32'(bus.out_valid), 32'd1);
    reset_pulse();
    set_tv(32'h0000_0800, 32'h0, 32'h0, 32'h0);
    run_group(16'hFFFF, 1'b1, {1'b0, 16'h0000}, 1'b0, 1);

    // randomized groups against the reference model
    for (int g = 0; g < 40; g++) begin
      set_tv(rand_term(), rand_term(), rand_term(), rand_term());
      run_group(16'($urandom), 1'b0, '0, 1'b1, $urandom_range(0, 4));
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
